// File: rtl/apb_regbank_pkg.sv
// ============================================================================
// Module : apb_regbank_pkg
// Brief  : Shared types and helpers for the parametrised APB register bank.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package apb_regbank_pkg;

   localparam int MAX_WAIT = 15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } apb_state_e;

   function automatic int lsb_of(input int dw);
      return (dw == 64) ? 3 : 2;
   endfunction

   // Operates at the widest legal bus; callers zero-extend and truncate.
   function automatic logic [63:0] strb_merge(input logic [63:0] old_v,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  strb);
      logic [63:0] res;
      res = old_v;
      for (int b = 0; b < 8; b++) begin
         if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/apb_wait_ctr.sv
// ============================================================================
// Module : apb_wait_ctr
// Brief  : Loadable down-counter with a done flag, sequencing APB wait states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module apb_wait_ctr #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             dec_i,
   output logic             done_o
);

   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - WIDTH'(1);
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/apb_regbank_n.sv
// ============================================================================
// Module : apb_regbank_n
// Brief  : Parametrised APB3/APB4 completer register bank with RO monitors.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module apb_regbank_n
   import apb_regbank_pkg::*;
#(
   parameter int                             ADDR_WIDTH  = 12,
   parameter int                             DATA_WIDTH  = 32,
   parameter int                             NUM_REGS    = 8,
   parameter int                             WAIT_STATES = 0,
   parameter bit                             APB4_EN     = 1'b1,
   parameter logic [NUM_REGS-1:0]            RO_MASK     = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] RST_VAL     = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           psel,
   input  logic                           penable,
   input  logic                           pwrite,
   input  logic [ADDR_WIDTH-1:0]          paddr,
   input  logic [DATA_WIDTH-1:0]          pwdata,
   input  logic [DATA_WIDTH/8-1:0]        pstrb,
   output logic                           pready,
   output logic [DATA_WIDTH-1:0]          prdata,
   output logic                           pslverr,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
   output logic [NUM_REGS-1:0]            wr_pulse,
   output logic [NUM_REGS-1:0]            rd_pulse
);

   localparam int              LSB      = lsb_of(DATA_WIDTH);
   localparam int              NB       = DATA_WIDTH / 8;
   localparam int              CTR_W    = $clog2(MAX_WAIT + 1);
   localparam logic [CTR_W-1:0] LOAD_VAL = (WAIT_STATES > 0) ? CTR_W'(WAIT_STATES - 1) : '0;

   apb_state_e              state_q, state_d;
   logic                    w_ctr_load, w_ctr_done, w_commit;
   logic [31:0]             w_idx;
   logic                    w_in_range, w_misalign, w_ro_hit, w_err;
   logic [DATA_WIDTH-1:0]   w_rd_src [NUM_REGS];
   logic [DATA_WIDTH-1:0]   w_cur, w_merged;
   logic [63:0]             w_merged64;
   logic [NB-1:0]           w_strb;
   logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
   logic                    pslverr_q, pslverr_d;
   logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d, rd_pulse_q, rd_pulse_d;
   logic                    w_unused;

   assign w_idx      = 32'(paddr[ADDR_WIDTH-1:LSB]);
   assign w_in_range = (w_idx < 32'(NUM_REGS));
   assign w_misalign = |paddr[LSB-1:0];

   always_comb begin
      w_cur    = '0;
      w_ro_hit = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_idx == 32'(i)) begin
            w_cur    = w_rd_src[i];
            w_ro_hit = RO_MASK[i];
         end
      end
   end

   assign w_err      = !w_in_range || w_misalign || (pwrite && w_ro_hit);
   assign w_strb     = APB4_EN ? pstrb : '1;
   assign w_merged64 = strb_merge(64'(w_cur), 64'(pwdata), 8'(w_strb));
   assign w_merged   = w_merged64[DATA_WIDTH-1:0];

   apb_wait_ctr #(.WIDTH(CTR_W)) u_wait_ctr (
      .clk        (clk),
      .rst        (rst),
      .load_i     (w_ctr_load),
      .load_val_i (LOAD_VAL),
      .dec_i      (state_q == ST_WAIT),
      .done_o     (w_ctr_done)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // w_commit marks the RESP-entry edge: writes and response capture happen there.
   always_comb begin
      state_d    = state_q;
      w_ctr_load = 1'b0;
      w_commit   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (psel && !penable) begin
               if (WAIT_STATES == 0) begin
                  state_d  = ST_RESP;
                  w_commit = 1'b1;
               end else begin
                  state_d    = ST_WAIT;
                  w_ctr_load = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (!psel) begin
               state_d = ST_IDLE;
            end else if (w_ctr_done) begin
               state_d  = ST_RESP;
               w_commit = 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      prdata_d   = '0;
      pslverr_d  = 1'b0;
      wr_pulse_d = '0;
      rd_pulse_d = '0;
      if (w_commit) begin
         if (w_err) begin
            pslverr_d = 1'b1;
         end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
               wr_pulse_d[i] = pwrite  && (w_idx == 32'(i));
               rd_pulse_d[i] = !pwrite && (w_idx == 32'(i));
            end
            if (!pwrite) prdata_d = w_cur;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prdata_q   <= '0;
         pslverr_q  <= 1'b0;
         wr_pulse_q <= '0;
         rd_pulse_q <= '0;
      end else begin
         prdata_q   <= prdata_d;
         pslverr_q  <= pslverr_d;
         wr_pulse_q <= wr_pulse_d;
         rd_pulse_q <= rd_pulse_d;
      end
   end

   generate
      for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
         if (RO_MASK[i]) begin : g_ro
            assign w_rd_src[i]                          = reg_in[i*DATA_WIDTH +: DATA_WIDTH];
            assign reg_out[i*DATA_WIDTH +: DATA_WIDTH]  = reg_in[i*DATA_WIDTH +: DATA_WIDTH];
         end else begin : g_rw
            logic [DATA_WIDTH-1:0] reg_q;
            always_ff @(posedge clk) begin
               if (rst) begin
                  reg_q <= RST_VAL[i*DATA_WIDTH +: DATA_WIDTH];
               end else if (w_commit && !w_err && pwrite && (w_idx == 32'(i))) begin
                  reg_q <= w_merged;
               end
            end
            assign w_rd_src[i]                         = reg_q;
            assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = reg_q;
         end
      end
   endgenerate

   assign pready   = (state_q == ST_RESP);
   assign prdata   = prdata_q;
   assign pslverr  = pslverr_q;
   assign wr_pulse = wr_pulse_q;
   assign rd_pulse = rd_pulse_q;

   // RW-register monitor inputs and the unused upper merge bits are intentionally dropped.
   assign w_unused = ^{reg_in, w_merged64};

endmodule

`default_nettype wire
